// File: rtl/inv_mix_pkg.sv
// rtl/inv_mix_pkg.sv - shared types and column transforms for inv_mix_unit
// Optional forward transform guarded by INV_MIX_FWD_EN.
package inv_mix_pkg;

    localparam int COL_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_e;

    function automatic logic [COL_W-1:0] inv_col(input logic [COL_W-1:0] c);
        logic [COL_W-1:0] b;
        b[3:0]   = c[7:4];
        b[4]     = c[8] ^ c[7];
        b[5]     = c[9] ^ c[4];
        b[6]     = c[10] ^ c[5];
        b[7]     = c[11] ^ c[6] ^ c[7];
        b[11:8]  = c[15:12];
        b[15:12] = c[3:0] ^ c[15:12];
        return b;
    endfunction

`ifdef INV_MIX_FWD_EN
    function automatic logic [COL_W-1:0] fwd_col(input logic [COL_W-1:0] b);
        logic [COL_W-1:0] c;
        c[3:0]   = b[11:8] ^ b[15:12];
        c[7:4]   = b[3:0];
        c[8]     = b[3] ^ b[4];
        c[9]     = b[0] ^ b[5];
        c[10]    = b[1] ^ b[6];
        c[11]    = b[2] ^ b[3] ^ b[7];
        c[15:12] = b[11:8];
        return c;
    endfunction
`endif

endpackage

// File: rtl/inv_mix_col.sv
// rtl/inv_mix_col.sv - combinational 16-bit column mixing transform
// mode selects the forward transform only when INV_MIX_FWD_EN is defined.
module inv_mix_col
    import inv_mix_pkg::*;
(
    input  logic             mode,
    input  logic [COL_W-1:0] col_in,
    output logic [COL_W-1:0] col_out
);

`ifdef INV_MIX_FWD_EN
    assign col_out = mode ? fwd_col(col_in) : inv_col(col_in);
`else
    logic mode_unused;
    assign mode_unused = mode;
    assign col_out     = inv_col(col_in);
`endif

endmodule

// File: rtl/inv_mix_unit.sv
// rtl/inv_mix_unit.sv - iterative mixing-layer engine, one column per clock
// Adds the mode port and forward transform when INV_MIX_FWD_EN is defined.
module inv_mix_unit
    import inv_mix_pkg::*;
#(
    parameter int NCOL = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [COL_W*NCOL-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COL_W*NCOL-1:0] out_data,
`ifdef INV_MIX_FWD_EN
    input  logic                  mode,
`endif
    output logic                  busy
);

    localparam int SW    = COL_W * NCOL;
    localparam int CNT_W = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(NCOL - 1);

    fsm_e             fsm_q, fsm_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [SW-1:0]    state_q, state_d;
    logic             mode_q, mode_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             mode_in;
    logic [COL_W-1:0] col_in, col_out;

`ifdef INV_MIX_FWD_EN
    assign mode_in = mode;
`else
    assign mode_in = 1'b0;
`endif

    assign col_in = state_q[col_q*COL_W +: COL_W];

    inv_mix_col u_col (
        .mode    (mode_q),
        .col_in  (col_in),
        .col_out (col_out)
    );

    always_comb begin
        fsm_d   = fsm_q;
        col_d   = col_q;
        state_d = state_q;
        mode_d  = mode_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = in_data;
                    col_d   = '0;
                    mode_d  = mode_in;
                    fsm_d   = BUSY;
                end
            end
            BUSY: begin
                state_d[col_q*COL_W +: COL_W] = col_out;
                if (col_q == LAST_COL) begin
                    fsm_d = DONE;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
        // Outputs are decoded from the next state so they leave as plain flops.
        in_ready_d  = (fsm_d == IDLE);
        out_valid_d = (fsm_d == DONE);
        busy_d      = (fsm_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            col_q       <= '0;
            state_q     <= '0;
            mode_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            col_q       <= col_d;
            state_q     <= state_d;
            mode_q      <= mode_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = state_q;

endmodule

// File: tb/tb_inv_mix_unit.sv
// tb/tb_inv_mix_unit.sv - directed self-checking bench for inv_mix_unit
// Forward-mode vectors are compiled in only with INV_MIX_FWD_EN.
module tb_inv_mix_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;
`ifdef INV_MIX_FWD_EN
    logic        mode;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    inv_mix_unit #(.NCOL(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef INV_MIX_FWD_EN
        .mode      (mode),
`endif
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [63:0] d, output logic [63:0] res, output int lat);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        if (!in_ready) check("run_op_ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (!out_valid) check("run_op_valid_timeout", 0, 1);
        res = out_data;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] res;
        logic [63:0] held;
        logic [63:0] vin [3];
        logic [63:0] vexp [3];
        logic [63:0] got_q [$];
        int          hs_q [$];
        int          lat;
        int          idx;
        int          cyc;
        logic        seen;
        logic        hs;
        logic        acc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
`ifdef INV_MIX_FWD_EN
        mode      = 1'b0;
`endif
        repeat (3) tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 64'h0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        run_op(64'h0000_0000_0000_0210, res, lat);
        check("inv_0210", res, 64'h0000_0000_0000_0001);
        check("latency", lat, 5);

        run_op(64'hFFFF_FFFF_FFFF_FFFF, res, lat);
        check("inv_ffff", res, 64'h0F8F_0F8F_0F8F_0F8F);

        run_op(64'h0000_0000_0980_0008, res, lat);
        check("inv_0008_0980", res, 64'h0000_0000_0008_8000);

        run_op(64'h0210_FFFF_0980_0008, res, lat);
        check("inv_mixed", res, 64'h0001_0F8F_0008_8000);

        // Backpressure: result must hold while out_ready stays low.
        in_valid = 1'b1;
        in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("bp_valid_rise", out_valid, 1);
        held = 64'h0F8F_0F8F_0F8F_0F8F;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_data  = 64'h0000_0000_0000_0210;
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, held);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_after_valid", out_valid, 0);
        check("bp_after_ready", in_ready, 1);
        tick();
        check("bp_no_capture_busy", busy, 0);

        // Reset in the second BUSY cycle discards the operation.
        in_valid = 1'b1;
        in_data  = 64'h1234_5678_9ABC_DEF0;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_data", out_data, 64'h0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("mid_rst_no_result", seen, 0);
        run_op(64'h0000_0000_0000_0210, res, lat);
        check("after_rst_op", res, 64'h0000_0000_0000_0001);

        // Back-to-back stream with in_valid held high.
        vin[0]  = 64'h0000_0000_0000_0210;
        vexp[0] = 64'h0000_0000_0000_0001;
        vin[1]  = 64'hFFFF_FFFF_FFFF_FFFF;
        vexp[1] = 64'h0F8F_0F8F_0F8F_0F8F;
        vin[2]  = 64'h0210_FFFF_0980_0008;
        vexp[2] = 64'h0001_0F8F_0008_8000;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = vin[0];
        idx = 0;
        cyc = 0;
        while (got_q.size() < 3 && cyc < 80) begin
            @(negedge clk);
            hs  = in_valid && in_ready;
            acc = out_valid && out_ready;
            if (acc) got_q.push_back(out_data);
            if (hs) hs_q.push_back(cyc);
            tick();
            cyc++;
            if (hs) begin
                idx++;
                if (idx < 3) in_data = vin[idx];
                else in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_count", got_q.size(), 3);
        check("b2b_hs_count", hs_q.size(), 3);
        if (got_q.size() == 3 && hs_q.size() == 3) begin
            for (int i = 0; i < 3; i++) check("b2b_data", got_q[i], vexp[i]);
            check("b2b_interval_0", hs_q[1] - hs_q[0], 6);
            check("b2b_interval_1", hs_q[2] - hs_q[1], 6);
        end
        tick();
        check("b2b_idle", busy, 0);

`ifdef INV_MIX_FWD_EN
        begin
            logic [63:0] d;
            logic [63:0] f;
            mode = 1'b1;
            run_op(64'h0000_0000_0000_0001, res, lat);
            check("fwd_0001", res, 64'h0000_0000_0000_0210);
            mode = 1'b0;
            run_op(res, f, lat);
            check("fwd_inv_back", f, 64'h0000_0000_0000_0001);
            for (int i = 0; i < 1000; i++) begin
                d = {$urandom(), $urandom()};
                mode = 1'b1;
                run_op(d, f, lat);
                mode = 1'b0;
                run_op(f, res, lat);
                check("round_trip", res, d);
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
